// File: rtl/fir_sequencer.sv
// fir_sequencer: coefficient serializer and sample handshake controller for a bit-serial FIR.
// Define FIR_SEQ_TIMEOUT_EN to add the WAIT watchdog and the sticky seq_timeout output.
module fir_sequencer #(
  parameter int DataWidth = 12,
  parameter int NTaps = 9,
  parameter int TimeoutCycles = 255,
  localparam int NCoeffs = (NTaps + 1) / 2,
  localparam int AW = $clog2(NCoeffs),
  localparam int BW = $clog2(DataWidth)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 coef_we,
  input  logic [AW-1:0]        coef_addr,
  input  logic [DataWidth-1:0] coef_wdata,
  input  logic                 coef_commit,
  output logic                 coef_busy,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DataWidth-1:0] s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [DataWidth-1:0] m_data,
  output logic                 fir_start,
  output logic [DataWidth-1:0] fir_x,
  output logic                 fir_coeff_load,
  output logic                 fir_coeff_in,
  input  logic                 fir_done,
  input  logic [DataWidth-1:0] fir_y
`ifdef FIR_SEQ_TIMEOUT_EN
  ,
  output logic                 seq_timeout
`endif
);
  typedef enum logic [1:0] {IDLE, LOAD, START, WAIT} state_e;
  if (NTaps % 2 == 0 || TimeoutCycles < 1) begin : g_bad_param
    $error("fir_sequencer: NTaps must be odd and TimeoutCycles positive");
  end
  state_e state_q, state_d;
  logic pend_q, pend_d, m_valid_q, m_valid_d, s_ready_q, s_ready_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [AW-1:0] word_q, word_d;
  logic [DataWidth-1:0] fir_x_q, fir_x_d, m_data_q, m_data_d;
  logic [DataWidth-1:0] bank_q [NCoeffs];
`ifdef FIR_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TimeoutCycles + 1);
  logic [TW-1:0] tmo_q, tmo_d;
  logic to_q, to_d;
  assign seq_timeout = to_q;
`endif
  assign coef_busy = pend_q | (state_q == LOAD);
  assign s_ready = s_ready_q;
  assign m_valid = m_valid_q;
  assign m_data = m_data_q;
  assign fir_x = fir_x_q;
  assign fir_start = state_q == START;
  assign fir_coeff_load = state_q == LOAD;
  assign fir_coeff_in = (state_q == LOAD) ? bank_q[word_q][bit_q] : 1'b0;
  always_comb begin
    state_d = state_q;
    pend_d = pend_q | coef_commit;
    bit_d = bit_q;
    word_d = word_q;
    fir_x_d = fir_x_q;
    m_valid_d = m_valid_q & ~m_ready;
    m_data_d = m_data_q;
`ifdef FIR_SEQ_TIMEOUT_EN
    tmo_d = (state_q == WAIT) ? tmo_q + 1'b1 : '0;
    to_d = to_q;
`endif
    case (state_q)
      IDLE: begin
        if (pend_q) begin
          state_d = LOAD;
          pend_d = coef_commit;
          bit_d = BW'(DataWidth - 1);
          word_d = AW'(NCoeffs - 1);
        end else if (s_valid && s_ready_q) begin
          fir_x_d = s_data;
          state_d = START;
        end
      end
      // Highest coefficient first, each word MSB first; last bit is word 0 bit 0.
      LOAD: begin
        bit_d = (bit_q == '0) ? BW'(DataWidth - 1) : bit_q - 1'b1;
        word_d = (bit_q == '0) ? word_q - 1'b1 : word_q;
        state_d = (bit_q == '0 && word_q == '0) ? IDLE : LOAD;
      end
      START: state_d = WAIT;
      WAIT: begin
        if (fir_done) begin
          m_valid_d = 1'b1;
          m_data_d = fir_y;
          state_d = IDLE;
        end
`ifdef FIR_SEQ_TIMEOUT_EN
        else if (tmo_q == TW'(TimeoutCycles - 1)) begin
          m_valid_d = 1'b1;
          m_data_d = '0;
          to_d = 1'b1;
          state_d = IDLE;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
    s_ready_d = state_d == IDLE && !pend_d && !m_valid_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q <= 1'b0;
      bit_q <= '0;
      word_q <= '0;
      fir_x_q <= '0;
      m_valid_q <= 1'b0;
      m_data_q <= '0;
      s_ready_q <= 1'b0;
      for (int i = 0; i < NCoeffs; i++) bank_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pend_q <= pend_d;
      bit_q <= bit_d;
      word_q <= word_d;
      fir_x_q <= fir_x_d;
      m_valid_q <= m_valid_d;
      m_data_q <= m_data_d;
      s_ready_q <= s_ready_d;
      if (coef_we && state_q != LOAD && int'(coef_addr) < NCoeffs) bank_q[coef_addr] <= coef_wdata;
    end
  end
`ifdef FIR_SEQ_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_q <= '0;
      to_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      to_q <= to_d;
    end
  end
`endif
endmodule
